// File: rtl/ctrl_pipe_if.sv
// Control-pipeline bus: ID-stage decode inputs, hazard controls, and the
// EX/MEM/WB control outputs. The ID stage/hazard unit drives the master side;
// ctrl_pipe sits on the slave side.
interface ctrl_pipe_if;
   // ID-stage instruction fields
   logic       id_valid;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   // hazard / redirect controls
   logic       clearcontrol;
   logic       stall;
   logic       flush_ex;
   // EX-stage control
   logic       ex_alusrc;
   logic [1:0] ex_aluop;
   logic       ex_branch;
   logic       ex_branchjalx;
   logic       ex_aluinputpc;
   logic       ex_alu2pc;
   logic       ex_mdu;
   logic       ex_illegal;
   // MEM-stage control
   logic       mem_memread;
   logic       mem_memwrite;
   logic       mem_memtoreg;
   logic       mem_regwrite;
   // WB-stage control
   logic       wb_memtoreg;
   logic       wb_regwrite;
   // front-end freeze and MDU status
   logic       id_hold;
   logic       mdu_busy;

   modport master (
      output id_valid, opcode, funct3, funct7, clearcontrol, stall, flush_ex,
      input  ex_alusrc, ex_aluop, ex_branch, ex_branchjalx, ex_aluinputpc,
             ex_alu2pc, ex_mdu, ex_illegal, mem_memread, mem_memwrite,
             mem_memtoreg, mem_regwrite, wb_memtoreg, wb_regwrite,
             id_hold, mdu_busy
   );

   modport slave (
      input  id_valid, opcode, funct3, funct7, clearcontrol, stall, flush_ex,
      output ex_alusrc, ex_aluop, ex_branch, ex_branchjalx, ex_aluinputpc,
             ex_alu2pc, ex_mdu, ex_illegal, mem_memread, mem_memwrite,
             mem_memtoreg, mem_regwrite, wb_memtoreg, wb_regwrite,
             id_hold, mdu_busy
   );
endinterface

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: decodes the ID-stage instruction into a control
// bundle and carries it through ID->EX->MEM->WB. A small FSM stretches
// multi-cycle MDU ops in EX, holding the front end and feeding bubbles to MEM.
module ctrl_pipe #(
   parameter int ENABLE_M    = 1,
   parameter int MDU_LATENCY = 4
) (
   input logic         clk,
   input logic         rst,
   ctrl_pipe_if.slave  bus
);

   // opcode[6:2] major groups
   localparam logic [4:0] OP_REG    = 5'b01100;
   localparam logic [4:0] OP_JALR   = 5'b11001;
   localparam logic [4:0] OP_IMML   = 5'b00000;
   localparam logic [4:0] OP_IMMOP  = 5'b00100;
   localparam logic [4:0] OP_STORE  = 5'b01000;
   localparam logic [4:0] OP_BRANCH = 5'b11000;
   localparam logic [4:0] OP_LUI    = 5'b01101;
   localparam logic [4:0] OP_AUIPC  = 5'b00101;
   localparam logic [4:0] OP_JAL    = 5'b11011;

   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   // last BUSY count; at this value the op leaves EX
   localparam logic [3:0] LAST  = 4'(MDU_LATENCY - 1);
   localparam bit         MULTI = (MDU_LATENCY > 1);

   typedef struct packed {
      logic       alusrc;
      logic [1:0] aluop;
      logic       branch;
      logic       branchjalx;
      logic       aluinputpc;
      logic       alu2pc;
      logic       mdu;
      logic       illegal;
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic       regwrite;
   } idex_t;

   typedef struct packed {
      logic memread;
      logic memwrite;
      logic memtoreg;
      logic regwrite;
   } exmem_t;

   typedef struct packed {
      logic memtoreg;
      logic regwrite;
   } memwb_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   idex_t      id_d;
   idex_t      idex_q;
   exmem_t     exmem_q;
   memwb_t     memwb_q;
   state_t     state_q;
   logic [3:0] cnt_q;
   logic       busy_q;
   logic       mdu_hold;
   logic [7:0] cw;
   logic       legal;

   // funct3 goes straight to the datapath; it is not part of the control word
   logic unused_funct3;
   assign unused_funct3 = ^bus.funct3;

   // ID decode: {alusrc,memtoreg,regwrite,memread,memwrite,branch,aluop}
   always_comb begin
      id_d  = '0;
      cw    = '0;
      legal = 1'b1;
      if (bus.id_valid && !bus.clearcontrol) begin
         if (bus.opcode[1:0] != 2'b11) begin
            legal = 1'b0;
         end else begin
            unique case (bus.opcode[6:2])
               OP_REG:    cw = 8'b00100010;
               OP_JALR:   cw = 8'b10100001;
               OP_IMML:   cw = 8'b11110000;
               OP_IMMOP:  cw = 8'b10100011;
               OP_STORE:  cw = 8'b10001000;
               OP_BRANCH: cw = 8'b00000101;
               OP_LUI:    cw = 8'b10100000;
               OP_AUIPC:  cw = 8'b10100000;
               OP_JAL:    cw = 8'b00100100;
               default:   legal = 1'b0;
            endcase
         end
         if (legal) begin
            id_d.alusrc     = cw[7];
            id_d.memtoreg   = cw[6];
            id_d.regwrite   = cw[5];
            id_d.memread    = cw[4];
            id_d.memwrite   = cw[3];
            id_d.branch     = cw[2];
            id_d.aluop      = cw[1:0];
            id_d.aluinputpc = (bus.opcode[6:2] == OP_AUIPC);
            id_d.branchjalx = (bus.opcode[6:2] == OP_JAL) ||
                              (bus.opcode[6:2] == OP_JALR);
            id_d.alu2pc     = (bus.opcode[6:2] == OP_JALR);
            id_d.mdu        = (ENABLE_M != 0) &&
                              (bus.opcode[6:2] == OP_REG) &&
                              (bus.funct7 == F7_MULDIV);
         end else begin
            id_d.illegal    = 1'b1;
         end
      end
   end

   // MDU keeps EX occupied until its last cycle; single-cycle latency never holds
   assign mdu_hold = ((state_q == S_IDLE) && idex_q.mdu && MULTI) ||
                     ((state_q == S_BUSY) && (cnt_q < LAST));

   // ID->EX: a held MDU op must not be overwritten, even by a flush
   always_ff @(posedge clk) begin
      if (!rst)                          idex_q <= '0;
      else if (bus.stall || mdu_hold)    idex_q <= idex_q;
      else if (bus.flush_ex)             idex_q <= '0;
      else                               idex_q <= id_d;
   end

   // EX->MEM: bubbles go downstream while the MDU op is still working
   always_ff @(posedge clk) begin
      if (!rst)              exmem_q <= '0;
      else if (bus.stall)    exmem_q <= exmem_q;
      else if (mdu_hold)     exmem_q <= '0;
      else                   exmem_q <= '{memread:  idex_q.memread,
                                          memwrite: idex_q.memwrite,
                                          memtoreg: idex_q.memtoreg,
                                          regwrite: idex_q.regwrite};
   end

   // MEM->WB: plain capture unless globally frozen
   always_ff @(posedge clk) begin
      if (!rst)              memwb_q <= '0;
      else if (bus.stall)    memwb_q <= memwb_q;
      else                   memwb_q <= '{memtoreg: exmem_q.memtoreg,
                                          regwrite: exmem_q.regwrite};
   end

   // MDU occupancy FSM: counts EX cycles of the current op, frozen by stall
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else if (!bus.stall) begin
         unique case (state_q)
            S_IDLE: begin
               if (mdu_hold) begin
                  state_q <= S_BUSY;
                  cnt_q   <= 4'd1;
                  busy_q  <= 1'b1;
               end
            end
            S_BUSY: begin
               if (cnt_q == LAST) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q   <= cnt_q + 4'd1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ex_alusrc     = idex_q.alusrc;
   assign bus.ex_aluop      = idex_q.aluop;
   assign bus.ex_branch     = idex_q.branch;
   assign bus.ex_branchjalx = idex_q.branchjalx;
   assign bus.ex_aluinputpc = idex_q.aluinputpc;
   assign bus.ex_alu2pc     = idex_q.alu2pc;
   assign bus.ex_mdu        = idex_q.mdu;
   assign bus.ex_illegal    = idex_q.illegal;
   assign bus.mem_memread   = exmem_q.memread;
   assign bus.mem_memwrite  = exmem_q.memwrite;
   assign bus.mem_memtoreg  = exmem_q.memtoreg;
   assign bus.mem_regwrite  = exmem_q.regwrite;
   assign bus.wb_memtoreg   = memwb_q.memtoreg;
   assign bus.wb_regwrite   = memwb_q.regwrite;
   assign bus.id_hold       = mdu_hold;
   assign bus.mdu_busy      = busy_q;

endmodule
